// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the two-master BRAM AXI4-Lite arbiter.
//   arb_state_e : arbiter FSM states
//   NUM_MASTERS : number of masters sharing the slave
//   BRESP_OKAY  : write response value returned by the BRAM
package bram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_XFER,
        WR_RESP
    } arb_state_e;

    localparam int unsigned NUM_MASTERS = 2;
    localparam logic [1:0]  BRESP_OKAY  = 2'b00;

endpackage

// File: rtl/bram_axi_arbiter_if.sv
// AXI4-Lite bundle (ar, r, aw, w, b channels) between one master and one slave.
//   master modport : drives addresses, write data, valids and r/b readies
//   slave modport  : drives ar/aw/w readies, read data, r/b valids and bresp
interface bram_axi_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid, bresp
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req       : request per master
//   last      : index of the master granted most recently
//   gnt_idx   : chosen master (the one not granted last when both request)
//   gnt_valid : at least one request present
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/bram_axi_arbiter.sv
// Shares one single-ported BRAM AXI4-Lite slave between two masters, one
// transaction (read or write) at a time, round-robin between masters.
// Handshakes are passed through combinationally while a grant is held.
//   clk, rst : clock, synchronous active-high reset
//   m0, m1   : master-facing ports (slave modport)
//   s        : BRAM-facing port (master modport)
//   grant    : index of the master owning the slave
//   busy     : high whenever the FSM is not idle
module bram_axi_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    bram_axi_arbiter_if.slave  m0,
    bram_axi_arbiter_if.slave  m1,
    bram_axi_arbiter_if.master s,
    output logic               grant,
    output logic               busy
);
    import bram_arb_pkg::*;

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    arb_state_e state_q;
    logic       last_q;
    logic       aw_done_q;
    logic       w_done_q;

    // Master-side signals gathered into arrays so they can be indexed by grant.
    logic [NUM_MASTERS-1:0] m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [NUM_MASTERS-1:0] m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [ADDR_WIDTH-1:0]  m_araddr [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0]  m_awaddr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  m_wdata  [NUM_MASTERS];
    logic [STRB_WIDTH-1:0]  m_wstrb  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  m_rdata  [NUM_MASTERS];
    logic [1:0]             m_bresp  [NUM_MASTERS];

    logic [ADDR_WIDTH-1:0]  s_araddr, s_awaddr;
    logic [DATA_WIDTH-1:0]  s_wdata;
    logic [STRB_WIDTH-1:0]  s_wstrb;
    logic                   s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;

    logic [1:0] req;
    logic       arb_idx;
    logic       arb_valid;
    logic       aw_done_nxt;
    logic       w_done_nxt;

    assign m_arvalid   = {m1.arvalid, m0.arvalid};
    assign m_rready    = {m1.rready,  m0.rready};
    assign m_awvalid   = {m1.awvalid, m0.awvalid};
    assign m_wvalid    = {m1.wvalid,  m0.wvalid};
    assign m_bready    = {m1.bready,  m0.bready};
    assign m_araddr[0] = m0.araddr;
    assign m_araddr[1] = m1.araddr;
    assign m_awaddr[0] = m0.awaddr;
    assign m_awaddr[1] = m1.awaddr;
    assign m_wdata[0]  = m0.wdata;
    assign m_wdata[1]  = m1.wdata;
    assign m_wstrb[0]  = m0.wstrb;
    assign m_wstrb[1]  = m1.wstrb;

    assign m0.arready = m_arready[0];
    assign m1.arready = m_arready[1];
    assign m0.rvalid  = m_rvalid[0];
    assign m1.rvalid  = m_rvalid[1];
    assign m0.rdata   = m_rdata[0];
    assign m1.rdata   = m_rdata[1];
    assign m0.awready = m_awready[0];
    assign m1.awready = m_awready[1];
    assign m0.wready  = m_wready[0];
    assign m1.wready  = m_wready[1];
    assign m0.bvalid  = m_bvalid[0];
    assign m1.bvalid  = m_bvalid[1];
    assign m0.bresp   = m_bresp[0];
    assign m1.bresp   = m_bresp[1];

    assign s.araddr  = s_araddr;
    assign s.arvalid = s_arvalid;
    assign s.rready  = s_rready;
    assign s.awaddr  = s_awaddr;
    assign s.awvalid = s_awvalid;
    assign s.wdata   = s_wdata;
    assign s.wstrb   = s_wstrb;
    assign s.wvalid  = s_wvalid;
    assign s.bready  = s_bready;

    assign req = m_arvalid | m_awvalid;

    rr_arbiter2 u_rr_arbiter2 (
        .req       (req),
        .last      (last_q),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // s_awvalid/s_wvalid are already masked once their channel is done.
    assign aw_done_nxt = aw_done_q | (s_awvalid & s.awready);
    assign w_done_nxt  = w_done_q  | (s_wvalid  & s.wready);

    always_comb begin
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rdata[i] = '0;
            m_bresp[i] = BRESP_OKAY;
        end
        unique case (state_q)
            RD_ADDR: begin
                s_araddr         = m_araddr[grant];
                s_arvalid        = m_arvalid[grant];
                m_arready[grant] = s.arready;
            end
            RD_DATA: begin
                m_rdata[grant]  = s.rdata;
                m_rvalid[grant] = s.rvalid;
                s_rready        = m_rready[grant];
            end
            WR_XFER: begin
                s_awaddr         = m_awaddr[grant];
                s_awvalid        = m_awvalid[grant] & ~aw_done_q;
                m_awready[grant] = s.awready & ~aw_done_q;
                s_wdata          = m_wdata[grant];
                s_wstrb          = m_wstrb[grant];
                s_wvalid         = m_wvalid[grant] & ~w_done_q;
                m_wready[grant]  = s.wready & ~w_done_q;
            end
            WR_RESP: begin
                m_bvalid[grant] = s.bvalid;
                m_bresp[grant]  = s.bresp;
                s_bready        = m_bready[grant];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant     <= 1'b0;
            busy      <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant <= arb_idx;
                        busy  <= 1'b1;
                        // Write first so a paired read of the same address sees new data.
                        state_q <= m_awvalid[arb_idx] ? WR_XFER : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (s_arvalid && s.arready) state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (s.rvalid && s_rready) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        last_q  <= grant;
                    end
                end
                WR_XFER: begin
                    if (aw_done_nxt && w_done_nxt) begin
                        state_q   <= WR_RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        aw_done_q <= aw_done_nxt;
                        w_done_q  <= w_done_nxt;
                    end
                end
                WR_RESP: begin
                    if (s.bvalid && s_bready) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                        last_q  <= grant;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_axi_arbiter.sv
// Scoreboard bench for bram_axi_arbiter: two master BFMs, a behavioural BRAM
// slave, and a negedge monitor that pops expected responses as they appear.
module tb_bram_axi_arbiter;
    import bram_arb_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_axi_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    bram_axi_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    bram_axi_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();

    logic grant, busy;

    bram_axi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .grant (grant),
        .busy  (busy)
    );

    // Master drive / observe arrays, index = master number.
    logic [AW-1:0] drv_araddr [2];
    logic [AW-1:0] drv_awaddr [2];
    logic [DW-1:0] drv_wdata  [2];
    logic [3:0]    drv_wstrb  [2];
    logic [1:0]    drv_arvalid, drv_rready, drv_awvalid, drv_wvalid, drv_bready;
    logic [1:0]    mon_arready, mon_rvalid, mon_awready, mon_wready, mon_bvalid;
    logic [DW-1:0] mon_rdata [2];
    logic [1:0]    mon_bresp [2];

    assign m0_if.araddr  = drv_araddr[0];
    assign m1_if.araddr  = drv_araddr[1];
    assign m0_if.arvalid = drv_arvalid[0];
    assign m1_if.arvalid = drv_arvalid[1];
    assign m0_if.rready  = drv_rready[0];
    assign m1_if.rready  = drv_rready[1];
    assign m0_if.awaddr  = drv_awaddr[0];
    assign m1_if.awaddr  = drv_awaddr[1];
    assign m0_if.awvalid = drv_awvalid[0];
    assign m1_if.awvalid = drv_awvalid[1];
    assign m0_if.wdata   = drv_wdata[0];
    assign m1_if.wdata   = drv_wdata[1];
    assign m0_if.wstrb   = drv_wstrb[0];
    assign m1_if.wstrb   = drv_wstrb[1];
    assign m0_if.wvalid  = drv_wvalid[0];
    assign m1_if.wvalid  = drv_wvalid[1];
    assign m0_if.bready  = drv_bready[0];
    assign m1_if.bready  = drv_bready[1];

    assign mon_arready  = {m1_if.arready, m0_if.arready};
    assign mon_rvalid   = {m1_if.rvalid,  m0_if.rvalid};
    assign mon_awready  = {m1_if.awready, m0_if.awready};
    assign mon_wready   = {m1_if.wready,  m0_if.wready};
    assign mon_bvalid   = {m1_if.bvalid,  m0_if.bvalid};
    assign mon_rdata[0] = m0_if.rdata;
    assign mon_rdata[1] = m1_if.rdata;
    assign mon_bresp[0] = m0_if.bresp;
    assign mon_bresp[1] = m1_if.bresp;

    // Behavioural BRAM slave: read data one cycle after ar, write after aw+w.
    logic [DW-1:0] bram    [1024];
    logic [DW-1:0] ref_mem [1024];
    logic          sl_rvalid, sl_aw_got, sl_w_got, sl_bvalid;
    logic [DW-1:0] sl_rdata, sl_wdata;
    logic [AW-1:0] sl_awaddr;
    logic [3:0]    sl_wstrb;
    int            sl_aw_cnt = 0;
    int            sl_w_cnt  = 0;

    assign s_if.arready = !sl_rvalid;
    assign s_if.rvalid  = sl_rvalid;
    assign s_if.rdata   = sl_rdata;
    assign s_if.awready = !sl_aw_got && !sl_bvalid;
    assign s_if.wready  = !sl_w_got && !sl_bvalid;
    assign s_if.bvalid  = sl_bvalid;
    assign s_if.bresp   = 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            sl_rvalid <= 1'b0;
            sl_rdata  <= '0;
            sl_aw_got <= 1'b0;
            sl_w_got  <= 1'b0;
            sl_bvalid <= 1'b0;
            sl_awaddr <= '0;
            sl_wdata  <= '0;
            sl_wstrb  <= '0;
        end else begin
            if (s_if.arvalid && s_if.arready) begin
                sl_rdata  <= bram[s_if.araddr];
                sl_rvalid <= 1'b1;
            end else if (sl_rvalid && s_if.rready) begin
                sl_rvalid <= 1'b0;
            end
            if (s_if.awvalid && s_if.awready) begin
                sl_aw_got <= 1'b1;
                sl_awaddr <= s_if.awaddr;
                sl_aw_cnt <= sl_aw_cnt + 1;
            end
            if (s_if.wvalid && s_if.wready) begin
                sl_w_got <= 1'b1;
                sl_wdata <= s_if.wdata;
                sl_wstrb <= s_if.wstrb;
                sl_w_cnt <= sl_w_cnt + 1;
            end
            if (sl_aw_got && sl_w_got) begin
                for (int b = 0; b < 4; b++)
                    if (sl_wstrb[b]) bram[sl_awaddr][8*b +: 8] <= sl_wdata[8*b +: 8];
                sl_bvalid <= 1'b1;
                sl_aw_got <= 1'b0;
                sl_w_got  <= 1'b0;
            end
            if (sl_bvalid && s_if.bready) sl_bvalid <= 1'b0;
        end
    end

    // Scoreboard state.
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_r0 [$];
    logic [DW-1:0] exp_r1 [$];
    int            exp_b0 = 0;
    int            exp_b1 = 0;
    int            ev_q [$];  // completions: 0/1 = read by m0/m1, 2/3 = write by m0/m1

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake, required one within %0d cycles", name, LIMIT);
    endtask

    task automatic mon_master(input logic m);
        logic [DW-1:0] e;
        if (mon_rvalid[m] && drv_rready[m]) begin
            ev_q.push_back(int'(m));
            if ((m ? exp_r1.size() : exp_r0.size()) == 0) begin
                check($sformatf("unexpected_r_m%0d", m), 32'd1, 32'd0);
            end else begin
                e = m ? exp_r1.pop_front() : exp_r0.pop_front();
                check($sformatf("rdata_m%0d", m), mon_rdata[m], e);
            end
        end
        if (mon_bvalid[m] && drv_bready[m]) begin
            ev_q.push_back(2 + int'(m));
            check($sformatf("b_expected_m%0d", m), 32'(m ? exp_b1 : exp_b0) > 0, 32'd1);
            if (m) exp_b1--; else exp_b0--;
            check($sformatf("bresp_m%0d", m), 32'(mon_bresp[m]), 32'(BRESP_OKAY));
        end
        if (!busy || grant != m) begin
            check($sformatf("quiet_m%0d", m),
                  {25'd0, mon_arready[m], mon_rvalid[m], mon_awready[m], mon_wready[m],
                   mon_bvalid[m], |mon_rdata[m], |mon_bresp[m]}, 32'd0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_master(1'b0);
                mon_master(1'b1);
                if (!busy) begin
                    check("quiet_slave",
                          {27'd0, s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid,
                           s_if.bready} | 32'(|s_if.araddr) | 32'(|s_if.awaddr)
                          | 32'(|s_if.wdata) | 32'(|s_if.wstrb), 32'd0);
                end
            end
        end
    end

    // Read transaction; expv is the hand-computed or model-derived read data.
    task automatic do_read(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] expv);
        int n;
        if (m) exp_r1.push_back(expv); else exp_r0.push_back(expv);
        drv_araddr[m]  = a;
        drv_arvalid[m] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mon_arready[m] && n < LIMIT);
        if (!mon_arready[m]) timeout_fail($sformatf("ar_m%0d", m));
        else check($sformatf("grant_ar_m%0d", m), 32'(grant), 32'(m));
        @(posedge clk); #1;
        drv_arvalid[m] = 1'b0;
        drv_araddr[m]  = '0;
        drv_rready[m]  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mon_rvalid[m] && n < LIMIT);
        if (!mon_rvalid[m]) timeout_fail($sformatf("r_m%0d", m));
        @(posedge clk); #1;
        drv_rready[m] = 1'b0;
    endtask

    // Write transaction; wvalid is raised w_delay cycles after awvalid.
    task automatic do_write(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] strb, input int w_delay);
        int   n, aw0, w0;
        logic aw_ok, w_ok, aw_hs, w_hs;
        for (int b = 0; b < 4; b++) if (strb[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        if (m) exp_b1++; else exp_b0++;
        aw0 = sl_aw_cnt;
        w0  = sl_w_cnt;
        drv_awaddr[m]  = a;
        drv_wdata[m]   = d;
        drv_wstrb[m]   = strb;
        drv_awvalid[m] = 1'b1;
        drv_wvalid[m]  = (w_delay == 0);
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        n = 0;
        while (!(aw_ok && w_ok) && n < LIMIT) begin
            @(negedge clk);
            aw_hs = drv_awvalid[m] && mon_awready[m];
            w_hs  = drv_wvalid[m] && mon_wready[m];
            if (!w_ok && !w_hs) check("no_early_b", 32'(mon_bvalid[m]), 32'd0);
            if (aw_ok) check("aw_not_reissued", {30'd0, s_if.awvalid, mon_awready[m]}, 32'd0);
            @(posedge clk); #1;
            n++;
            if (aw_hs) begin aw_ok = 1'b1; drv_awvalid[m] = 1'b0; end
            if (w_hs) begin w_ok = 1'b1; drv_wvalid[m] = 1'b0; end
            if (n == w_delay && !w_ok) drv_wvalid[m] = 1'b1;
        end
        if (!(aw_ok && w_ok)) timeout_fail($sformatf("aw_w_m%0d", m));
        drv_bready[m] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mon_bvalid[m] && n < LIMIT);
        if (!mon_bvalid[m]) timeout_fail($sformatf("b_m%0d", m));
        @(posedge clk); #1;
        drv_bready[m] = 1'b0;
        check("slave_aw_count", 32'(sl_aw_cnt - aw0), 32'd1);
        check("slave_w_count", 32'(sl_w_cnt - w0), 32'd1);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, required one within 60000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, alt_err, cnt0, cnt1;

        for (int i = 0; i < 1024; i++) begin
            bram[i]    = 32'h1000_0000 + i * 32'h0001_0101;
            ref_mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
        end
        bram[4]    = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        bram[8]    = 32'hCAFEBABE;
        ref_mem[8] = 32'hCAFEBABE;
        for (int m = 0; m < 2; m++) begin
            drv_araddr[m] = '0;
            drv_awaddr[m] = '0;
            drv_wdata[m]  = '0;
            drv_wstrb[m]  = '0;
        end
        drv_arvalid = '0;
        drv_rready  = '0;
        drv_awvalid = '0;
        drv_wvalid  = '0;
        drv_bready  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Single read by m0.
        @(posedge clk); #1;
        do_read(1'b0, 10'h004, 32'hDEADBEEF);
        @(negedge clk);
        check("busy_after_read", 32'(busy), 32'd0);

        // Simultaneous reads from reset, then a repeated tie.
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        base = ev_q.size();
        fork
            do_read(1'b0, 10'h010, ref_mem[10'h010]);
            do_read(1'b1, 10'h020, ref_mem[10'h020]);
        join
        fork
            do_read(1'b0, 10'h010, ref_mem[10'h010]);
            do_read(1'b1, 10'h020, ref_mem[10'h020]);
        join
        if (ev_q.size() < base + 4) check("tie_events", 32'(ev_q.size() - base), 32'd4);
        else check("tie_order", 32'((ev_q[base] << 12) | (ev_q[base+1] << 8)
                                    | (ev_q[base+2] << 4) | ev_q[base+3]), 32'h0101);

        // Write and read of the same address by m1 together: write goes first.
        @(posedge clk); #1;
        base = ev_q.size();
        fork
            do_write(1'b1, 10'h008, 32'h12345678, 4'b0011, 0);
            do_read(1'b1, 10'h008, 32'hCAFE5678);
        join
        if (ev_q.size() < base + 2) check("wr_rd_events", 32'(ev_q.size() - base), 32'd2);
        else check("wr_rd_order", 32'((ev_q[base] << 4) | ev_q[base+1]), 32'h31);

        // Skewed aw/w channels on m0, then read back.
        @(posedge clk); #1;
        do_write(1'b0, 10'h030, 32'hA1B2C3D4, 4'hF, 4);
        do_read(1'b0, 10'h030, 32'hA1B2C3D4);

        // Reset while m0 sits in the read-data phase.
        @(posedge clk); #1;
        drv_araddr[0]  = 10'h040;
        drv_arvalid[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!mon_arready[0] && n < LIMIT);
        if (!mon_arready[0]) timeout_fail("ar_before_reset");
        @(posedge clk); #1;
        drv_arvalid[0] = 1'b0;
        drv_araddr[0]  = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_data_busy", 32'(busy), 32'd1);
        check("rd_data_rvalid_m0", 32'(mon_rvalid[0]), 32'd1);
        check("rd_data_rdata_m0", mon_rdata[0], ref_mem[10'h040]);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_valids", {28'd0, mon_rvalid, s_if.arvalid, s_if.rready}, 32'd0);
        @(posedge clk); #1;
        do_read(1'b1, 10'h050, ref_mem[10'h050]);

        // Continuous streams from both masters: grants must alternate.
        @(posedge clk); #1;
        base = ev_q.size();
        fork
            begin
                for (int i = 0; i < 50; i++)
                    do_read(1'b0, AW'(i * 7), ref_mem[AW'(i * 7)]);
            end
            begin
                for (int i = 0; i < 50; i++)
                    do_read(1'b1, AW'(i * 13 + 256), ref_mem[AW'(i * 13 + 256)]);
            end
        join
        alt_err = 0;
        cnt0    = 0;
        cnt1    = 0;
        for (int i = base; i < ev_q.size(); i++) begin
            if (ev_q[i] == 0) cnt0++;
            if (ev_q[i] == 1) cnt1++;
            if (i > base && ev_q[i] == ev_q[i-1]) alt_err++;
        end
        check("stream_m0_count", 32'(cnt0), 32'd50);
        check("stream_m1_count", 32'(cnt1), 32'd50);
        check("stream_alternation", 32'(alt_err), 32'd0);

        repeat (3) @(posedge clk);
        check("exp_r0_drained", 32'(exp_r0.size()), 32'd0);
        check("exp_r1_drained", 32'(exp_r1.size()), 32'd0);
        check("exp_b_drained", 32'(exp_b0 + exp_b1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_axi_arbiter.md
# bram_axi_arbiter

Two-master AXI4-Lite arbiter that shares the single-ported firmware BRAM slave (`bram_axi`) between the CPU instruction-fetch port (master 0) and the data/load-store port (master 1). It owns the slave for exactly one transaction at a time, read or write, and uses round-robin fairness between the masters. All slave handshakes are passed through combinationally while a grant is held. It sits between the core's bus ports and the BRAM in the V1 SoC top.

## Interface
Parameters:
- ADDR_WIDTH, 10, word address width; matches BRAM slave.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.

Ports (N ∈ {0,1}; every mN_ line exists once per master):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mN_araddr  in  ADDR_WIDTH  read address.
- mN_arvalid  in  1 / mN_arready  out  1  read-address handshake.
- mN_rdata  out  DATA_WIDTH / mN_rvalid  out  1 / mN_rready  in  1  read-data channel.
- mN_awaddr  in  ADDR_WIDTH / mN_awvalid  in  1 / mN_awready  out  1  write-address channel.
- mN_wdata  in  DATA_WIDTH / mN_wstrb  in  DATA_WIDTH/8 / mN_wvalid  in  1 / mN_wready  out  1  write-data channel.
- mN_bvalid  out  1 / mN_bready  in  1 / mN_bresp  out  2  write-response channel.
- s_araddr, s_arvalid  out / s_arready  in  same widths as above; toward the BRAM slave.
- s_rdata, s_rvalid  in / s_rready  out.
- s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid  out / s_awready, s_wready  in.
- s_bvalid, s_bresp  in / s_bready  out.
- grant  out  1  index of the master that currently owns the slave.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP.
- IDLE:
  - A master requests if its arvalid or awvalid is high.
  - If both masters request, grant goes to the master that was not granted last. The pointer resets to "last = 1", so master 0 wins the first tie.
  - If the granted master has both awvalid and arvalid high, the write is served first so that a read of the same address returns the new data.
  - Next state is WR_XFER or RD_ADDR. The `grant` register is loaded on this edge.
- RD_ADDR:
  - Connect s_ar* ↔ m[grant]_ar*.
  - When s_arvalid && s_arready → RD_DATA.
- RD_DATA:
  - Connect s_r* ↔ m[grant]_r*.
  - When s_rvalid && s_rready → IDLE and update the last pointer.
- WR_XFER:
  - Forward aw and w independently.
  - Flags aw_done and w_done are set on their respective handshakes.
  - After a channel's handshake, its valid toward the slave and its ready toward the master are masked low.
  - When both flags are set (including both on the same cycle) → WR_RESP, and both flags clear.
- WR_RESP:
  - Forward the b channel.
  - When s_bvalid && s_bready → IDLE and update the last pointer.
- Non-granted master: all of its ready and valid outputs are 0, and all of its data outputs are 0.
- In IDLE, every output toward the slave and every ready/valid toward the masters is 0.
- mN_bresp is forwarded unchanged. The BRAM always returns OKAY (2'b00).

## Timing
- Reset: state IDLE, grant 0, last 1, busy 0, aw_done 0, w_done 0. All valids and readies 0. All data outputs 0.
- Arbitration costs 1 cycle: a request seen in IDLE at edge k is forwarded to the slave from cycle k+1.
- Pass-through adds 0 cycles of latency. There is no registering on data paths.
- Back-to-back transactions: the edge that completes a transaction returns to IDLE, so the next grant is issued 1 cycle after completion.
- A master must hold valid and payload until the handshake; this is an AXI rule.
- A requester that drops arvalid or awvalid in IDLE before being granted is ignored, with no lock-up.
- When rst is asserted mid-transaction: return to IDLE on the next edge and drop all forwarding. The slave is reset by the same rst.
- No timeout. A slave that never responds holds the grant indefinitely.

## Structure
- Package bram_arb_pkg: state enum (IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP), NUM_MASTERS=2, BRESP_OKAY=2'b00.
- Sub-module rr_arbiter2: inputs req[1:0] and a last pointer; outputs gnt_idx and gnt_valid. Purely combinational. The top holds the last-pointer register.
- Top: FSM, done flags, channel muxes and demuxes.

## Test plan
- Single read: m0 reads addr 0x004 while the BRAM holds 0xDEADBEEF → m0_rdata=0xDEADBEEF with m0_rvalid high; m1 sees no activity; busy returns to 0.
- Simultaneous reads: m0 and m1 both assert arvalid from reset at addrs 0x010 and 0x020 → m0 is served first, then m1; a repeat of the tie is granted to m0 again, because the last pointer alternates.
- Write-then-read priority: m1 asserts awaddr 0x008, wdata 0x12345678, wstrb 4'b0011, and arvalid at 0x008, all together → the write completes first (bresp 00), then the read returns 0xXXXX5678 with the upper bytes keeping their old value.
- Skewed write channels: m0 sends aw at cycle 3 and w at cycle 7 → aw is not re-issued, the slave sees exactly one aw handshake and one w handshake, and the state advances to WR_RESP only after cycle 7.
- Reset mid-read: rst asserted while in RD_DATA → next cycle busy=0, all valids=0, and a new m1 request is granted normally afterward.
- Continuous m0 and m1 read streams for 100 transactions → each master is granted within 1 transaction of the other, with no starvation; a scoreboard matches every read's data against a model of the BRAM contents.
